// File: rtl/data_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_ctrl_if
// Description : Pipeline-side and SRAM-side signals of the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_cache_ctrl_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  mem_r_en, mem_w_en, addr, wdata, flush, sram_rdata, sram_ready,
        output rdata, ready, sram_r_en, sram_w_en, sram_addr, sram_wdata
    );

    modport master (
        output mem_r_en, mem_w_en, addr, wdata, flush, sram_rdata, sram_ready,
        input  rdata, ready, sram_r_en, sram_w_en, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/data_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_ctrl
// Description : 2-way set-associative write-through data cache, 2-word lines.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_ctrl #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 29 - INDEX_W
) (
    input  wire logic         clk,
    input  wire logic         rst,
    data_cache_ctrl_if.slave  bus
);
    localparam int c_sets = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_WR_THRU = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       valid_q [c_sets];
    logic             lru_q   [c_sets];
    logic [TAG_W-1:0] tag_q   [c_sets][2];
    logic [63:0]      line_q  [c_sets][2];

    logic        sram_r_en_q, sram_r_en_d;
    logic        sram_w_en_q, sram_w_en_d;
    logic [31:0] sram_addr_q, sram_addr_d;
    logic [31:0] sram_wdata_q, sram_wdata_d;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_word;
    logic [1:0]         w_way_hit;
    logic               w_hit;
    logic               w_hit_way;
    logic [63:0]        w_hit_line;
    logic               w_victim;
    logic               w_ready;
    logic [31:0]        w_rdata;
    logic               w_fill;
    logic               w_wr_hit;
    logic               w_touch;
    logic               w_touch_way;
    logic               w_flush_all;

    assign w_idx  = bus.addr[INDEX_W+2:3];
    assign w_tag  = bus.addr[31:INDEX_W+3];
    assign w_word = bus.addr[2];

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            w_way_hit[w] = valid_q[w_idx][w] && (tag_q[w_idx][w] == w_tag);
        end
    end

    assign w_hit      = |w_way_hit;
    assign w_hit_way  = w_way_hit[1];
    assign w_hit_line = line_q[w_idx][w_hit_way];
    // Fill an empty way first (way0 before way1), otherwise evict the LRU way
    assign w_victim   = !valid_q[w_idx][0] ? 1'b0 :
                        !valid_q[w_idx][1] ? 1'b1 : lru_q[w_idx];

    always_comb begin
        state_d      = state_q;
        w_ready      = 1'b1;
        w_rdata      = '0;
        w_fill       = 1'b0;
        w_wr_hit     = 1'b0;
        w_touch      = 1'b0;
        w_touch_way  = 1'b0;
        w_flush_all  = 1'b0;
        sram_r_en_d  = sram_r_en_q;
        sram_w_en_d  = sram_w_en_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    w_ready = 1'b0;
                    state_d = S_FLUSH;
                end else if (bus.mem_w_en) begin
                    w_ready      = 1'b0;
                    state_d      = S_WR_THRU;
                    sram_w_en_d  = 1'b1;
                    sram_addr_d  = bus.addr;
                    sram_wdata_d = bus.wdata;
                end else if (bus.mem_r_en) begin
                    if (w_hit) begin
                        w_rdata     = w_word ? w_hit_line[63:32] : w_hit_line[31:0];
                        w_touch     = 1'b1;
                        w_touch_way = w_hit_way;
                    end else begin
                        w_ready     = 1'b0;
                        state_d     = S_RD_MISS;
                        sram_r_en_d = 1'b1;
                        sram_addr_d = {bus.addr[31:3], 3'b000};
                    end
                end
            end
            S_RD_MISS: begin
                w_ready = bus.sram_ready;
                if (bus.sram_ready) begin
                    w_rdata     = w_word ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
                    w_fill      = 1'b1;
                    w_touch     = 1'b1;
                    w_touch_way = w_victim;
                    state_d     = S_IDLE;
                    sram_r_en_d = 1'b0;
                    sram_addr_d = '0;
                end
            end
            S_WR_THRU: begin
                w_ready = bus.sram_ready;
                if (bus.sram_ready) begin
                    w_wr_hit     = w_hit;
                    w_touch      = w_hit;
                    w_touch_way  = w_hit_way;
                    state_d      = S_IDLE;
                    sram_w_en_d  = 1'b0;
                    sram_addr_d  = '0;
                    sram_wdata_d = '0;
                end
            end
            S_FLUSH: begin
                w_ready     = 1'b0;
                w_flush_all = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!rst) begin
            w_ready = 1'b1;
            w_rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            sram_r_en_q  <= 1'b0;
            sram_w_en_q  <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            for (int s = 0; s < c_sets; s++) begin
                valid_q[s] <= '0;
                lru_q[s]   <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            sram_r_en_q  <= sram_r_en_d;
            sram_w_en_q  <= sram_w_en_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if (w_flush_all) begin
                for (int s = 0; s < c_sets; s++) begin
                    valid_q[s] <= '0;
                    lru_q[s]   <= 1'b0;
                end
            end else begin
                if (w_fill) begin
                    valid_q[w_idx][w_victim] <= 1'b1;
                end
                if (w_touch) begin
                    lru_q[w_idx] <= ~w_touch_way;
                end
            end
        end
    end

    // Tags and data need no reset: valid bits gate every use of them
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_fill) begin
                tag_q[w_idx][w_victim]  <= w_tag;
                line_q[w_idx][w_victim] <= bus.sram_rdata;
            end
            if (w_wr_hit) begin
                if (w_word) begin
                    line_q[w_idx][w_hit_way][63:32] <= bus.wdata;
                end else begin
                    line_q[w_idx][w_hit_way][31:0]  <= bus.wdata;
                end
            end
        end
    end

    assign bus.ready      = w_ready;
    assign bus.rdata      = w_rdata;
    assign bus.sram_r_en  = sram_r_en_q;
    assign bus.sram_w_en  = sram_w_en_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
endmodule
`default_nettype wire
